// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: operand width,
// iteration count and controller state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_ITER  = 8;
  localparam int CNT_W     = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/subtractor_8bit.sv
// 8-bit ripple subtractor computing numberA - numberB as A + ~B + 1.
// cout = 1 means no borrow (numberA >= numberB).
module subtractor_8bit (
  input  logic [7:0] numberA,
  input  logic [7:0] numberB,
  output logic [7:0] result,
  output logic       cout
);

  logic [8:0] carry;
  logic [7:0] nb;

  assign nb       = ~numberB;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign result[i]  = numberA[i] ^ nb[i] ^ carry[i];
    assign carry[i+1] = (numberA[i] & nb[i]) | (numberA[i] & carry[i]) | (nb[i] & carry[i]);
  end

  assign cout = carry[8];

endmodule

// File: rtl/divider_seq_ctrl.sv
// 8-bit unsigned restoring divider, one quotient bit per clock, valid/ready on
// both sides. Define DIVIDER_DBZ_EN to short-circuit a zero divisor into DONE.
module divider_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divZero,
  output logic             busy
);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] q, r, d;
  logic [CNT_W-1:0] cnt;

  logic             msb, cout, take, accept, consume, last_iter, dz_start;
  logic [WIDTH-1:0] s, diff;

  // The bit leaving R stands for 256; if set, the subtraction always fits.
  assign {msb, s} = {r, q[WIDTH-1]};

  subtractor_8bit u_sub (
    .numberA (s),
    .numberB (d),
    .result  (diff),
    .cout    (cout)
  );

  assign take      = msb | cout;
  assign accept    = inValid & inReady;
  assign consume   = outValid & outReady;
  assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));

`ifdef DIVIDER_DBZ_EN
  logic dz_q;

  assign dz_start = (divisor == '0);
  assign divZero  = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dz_q <= 1'b0;
    else if (accept)  dz_q <= dz_start;
    else if (consume) dz_q <= 1'b0;
  end
`else
  assign dz_start = 1'b0;
  assign divZero  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_nxt = dz_start ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (accept) begin
      // A zero-divisor short cut loads the same result the iterations would produce.
      q   <= dz_start ? '1 : dividend;
      r   <= dz_start ? dividend : '0;
      d   <= divisor;
      cnt <= '0;
    end else if (state == RUN) begin
      r   <= take ? diff : s;
      q   <= {q[WIDTH-2:0], take};
      cnt <= cnt + 1'b1;
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule
